// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: standard VGA mode constants and the line/frame period helper.
package vga_timing_pkg;
  typedef struct packed {
    int unsigned vis;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
    logic        pol;
  } vga_axis_t;
  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_mode_t;
  localparam vga_mode_t MODE_640X480_60  = '{h: '{640, 16, 96, 48, 1'b0}, v: '{480, 10, 2, 33, 1'b0}};
  localparam vga_mode_t MODE_800X600_60  = '{h: '{800, 40, 128, 88, 1'b1}, v: '{600, 1, 4, 23, 1'b1}};
  localparam vga_mode_t MODE_1024X768_60 = '{h: '{1024, 24, 136, 160, 1'b0}, v: '{768, 3, 6, 29, 1'b0}};
  function automatic int unsigned vga_period(input int unsigned vis, front, sync, back);
    return vis + front + sync + back;
  endfunction
endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer: wrapping raster counter for one axis with registered visible/sync flags.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int   CW    = 11,
  parameter int   VIS   = 640,
  parameter int   FRONT = 16,
  parameter int   SYNC  = 96,
  parameter int   BACK  = 48,
  parameter logic POL   = 1'b0
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic          vis,
  output logic          sync
);
  localparam int PER = int'(vga_period(VIS, FRONT, SYNC, BACK));
  localparam logic [CW-1:0] LAST = CW'(PER - 1);
  localparam logic [CW-1:0] VEND = CW'(VIS);
  localparam logic [CW-1:0] SBEG = CW'(VIS + FRONT);
  localparam logic [CW-1:0] SEND = CW'(VIS + FRONT + SYNC);
  logic [CW-1:0] cnt_q, cnt_d, nxt;
  logic          vis_q, vis_d, sync_q, sync_d;
  // flags are decoded from the next count so they line up with cnt on the same edge
  always_comb begin
    last   = cnt_q == LAST;
    nxt    = last ? '0 : cnt_q + 1'b1;
    cnt_d  = adv ? nxt : cnt_q;
    vis_d  = adv ? nxt < VEND : vis_q;
    sync_d = adv ? ((nxt >= SBEG && nxt < SEND) ? POL : ~POL) : sync_q;
  end
  always_ff @(posedge clk) begin
    if (!clrn) begin
      cnt_q  <= LAST;
      vis_q  <= 1'b0;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      vis_q  <= vis_d;
      sync_q <= sync_d;
    end
  end
  assign cnt  = cnt_q;
  assign vis  = vis_q;
  assign sync = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with a pixel clock-enable divider.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   DIV    = 2,
  parameter int   CW     = 11,
  parameter int   HVIS   = 640,
  parameter int   HFRONT = 16,
  parameter int   HSYNC  = 96,
  parameter int   HBACK  = 48,
  parameter int   VVIS   = 480,
  parameter int   VFRONT = 10,
  parameter int   VSYNC  = 2,
  parameter int   VBACK  = 33,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic          CLK,
  input  logic          clrn,
  output logic          PCE,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          DE,
  output logic [CW-1:0] HCNT,
  output logic [CW-1:0] VCNT,
  output logic          LINE_START,
  output logic          FRAME_START
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  if (longint'(vga_period(HVIS, HFRONT, HSYNC, HBACK)) > (longint'(1) << CW) ||
      longint'(vga_period(VVIS, VFRONT, VSYNC, VBACK)) > (longint'(1) << CW)) begin : g_chk
    $error("vga_timing_gen: line or frame period does not fit in CW bits");
  end
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          tick, h_last, v_last, h_vis, v_vis;
  logic          pce_q, pce_d, ls_q, ls_d, fs_q, fs_d;
  always_comb begin
    tick   = dcnt_q == DW'(DIV - 1);
    dcnt_d = tick ? '0 : dcnt_q + 1'b1;
    pce_d  = tick;
    ls_d   = tick & h_last;
    fs_d   = tick & h_last & v_last;
  end
  always_ff @(posedge CLK) begin
    if (!clrn) begin
      dcnt_q <= '0;
      pce_q  <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      dcnt_q <= dcnt_d;
      pce_q  <= pce_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end
  vga_axis_timer #(
    .CW(CW), .VIS(HVIS), .FRONT(HFRONT), .SYNC(HSYNC), .BACK(HBACK), .POL(HS_POL)
  ) u_h (
    .clk(CLK), .clrn(clrn), .adv(tick), .cnt(HCNT), .last(h_last), .vis(h_vis), .sync(VGA_HS)
  );
  // the vertical axis only moves on a line wrap, so VS can only change with LINE_START
  vga_axis_timer #(
    .CW(CW), .VIS(VVIS), .FRONT(VFRONT), .SYNC(VSYNC), .BACK(VBACK), .POL(VS_POL)
  ) u_v (
    .clk(CLK), .clrn(clrn), .adv(tick & h_last), .cnt(VCNT), .last(v_last), .vis(v_vis), .sync(VGA_VS)
  );
  assign DE          = h_vis & v_vis;
  assign PCE         = pce_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;
endmodule
